// File: rtl/matrix_frame_capture.sv
// rtl/matrix_frame_capture.sv - receive side of the 5x7 column-scanned LED matrix; rebuilds frames and flags scan errors
module matrix_frame_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_DWELL   = 4,
    parameter int COL_ACT_LOW = 1,
    parameter int ROW_ACT_LOW = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] matrix_col,
    input  logic [6:0] matrix_row,
    output logic [6:0] frame_col_4,
    output logic [6:0] frame_col_3,
    output logic [6:0] frame_col_2,
    output logic [6:0] frame_col_1,
    output logic [6:0] frame_col_0,
    output logic       frame_valid,
    output logic       frame_changed,
    output logic [7:0] frame_count,
    output logic       seq_err,
    output logic [7:0] err_count
);

    localparam logic [1:0] WAIT_START = 2'd0;
    localparam logic [1:0] CAPTURE    = 2'd1;
    localparam logic [1:0] COMMIT     = 2'd2;

    localparam logic [4:0] COL_IDLE = (COL_ACT_LOW != 0) ? 5'h1F : 5'h00;
    localparam logic [6:0] ROW_IDLE = (ROW_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam int         DW       = $clog2(MIN_DWELL + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);

    logic [4:0] col_s;
    logic [6:0] row_s;

    // Synchronizers power up at the idle level so reset never looks like a selected column.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign col_s = matrix_col;
            assign row_s = matrix_row;
        end else begin : g_sync
            logic [11:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= {COL_IDLE, ROW_IDLE};
                end else begin
                    sync_q[0] <= {matrix_col, matrix_row};
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign {col_s, row_s} = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [4:0] col_n;
    logic [6:0] row_n;
    assign col_n = (COL_ACT_LOW != 0) ? ~col_s : col_s;
    assign row_n = (ROW_ACT_LOW != 0) ? ~row_s : row_s;

    logic [1:0]      state_q, state_d;
    logic [11:0]     prev_q;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [2:0]      exp_col_q, exp_col_d;
    logic [2:0]      last_col_q, last_col_d;
    logic [4:0][6:0] shadow_q, shadow_d;
    logic [4:0][6:0] frame_q, frame_d;
    logic            frame_valid_q, frame_valid_d;
    logic            frame_changed_q, frame_changed_d;
    logic [7:0]      frame_count_q, frame_count_d;
    logic            seq_err_q, seq_err_d;
    logic [7:0]      err_count_q, err_count_d;

    logic       blank, onehot, multi, same, accept, multi_first;
    logic [2:0] col_idx;

    always_comb begin
        col_idx = 3'd0;
        for (int k = 0; k < 5; k++) begin
            if (col_n[k]) col_idx = 3'(k);
        end
        blank  = (col_n == 5'd0);
        onehot = !blank && ((col_n & (col_n - 5'd1)) == 5'd0);
        multi  = !blank && !onehot;
        same   = ({col_n, row_n} == prev_q);

        if (blank) begin
            dwell_d = '0;
        end else if (same) begin
            dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
        end else begin
            dwell_d = DW'(1);
        end

        // Accept exactly once per stable slot: on the cycle the count first reaches the threshold.
        accept      = onehot && (dwell_d == DWELL_MAX) && !(same && (dwell_q == DWELL_MAX));
        multi_first = multi && !same;
    end

    always_comb begin
        state_d         = state_q;
        exp_col_d       = exp_col_q;
        last_col_d      = last_col_q;
        shadow_d        = shadow_q;
        frame_d         = frame_q;
        frame_valid_d   = 1'b0;
        frame_changed_d = 1'b0;
        frame_count_d   = frame_count_q;
        seq_err_d       = 1'b0;

        case (state_q)
            WAIT_START: begin
                if (multi_first) begin
                    seq_err_d = 1'b1;
                end else if (accept && (col_idx == 3'd4)) begin
                    shadow_d[4] = row_n;
                    exp_col_d   = 3'd3;
                    last_col_d  = 3'd4;
                    state_d     = CAPTURE;
                end
            end
            CAPTURE: begin
                if (multi_first) begin
                    seq_err_d = 1'b1;
                    state_d   = WAIT_START;
                end else if (accept) begin
                    if (col_idx == last_col_q) begin
                        shadow_d[col_idx] = row_n;
                    end else if (col_idx == exp_col_q) begin
                        shadow_d[col_idx] = row_n;
                        last_col_d        = col_idx;
                        exp_col_d         = 3'(exp_col_q - 3'd1);
                        if (col_idx == 3'd0) state_d = COMMIT;
                    end else begin
                        seq_err_d = 1'b1;
                        if (col_idx == 3'd4) begin
                            shadow_d[4] = row_n;
                            exp_col_d   = 3'd3;
                            last_col_d  = 3'd4;
                        end else begin
                            state_d = WAIT_START;
                        end
                    end
                end
            end
            COMMIT: begin
                frame_d         = shadow_q;
                frame_valid_d   = 1'b1;
                frame_changed_d = (shadow_q != frame_q);
                frame_count_d   = frame_count_q + 8'd1;
                seq_err_d       = multi_first;
                state_d         = WAIT_START;
            end
            default: state_d = WAIT_START;
        endcase

        err_count_d = (seq_err_d && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= WAIT_START;
            prev_q          <= '0;
            dwell_q         <= '0;
            exp_col_q       <= 3'd4;
            last_col_q      <= 3'd4;
            shadow_q        <= '0;
            frame_q         <= '0;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            frame_count_q   <= 8'd0;
            seq_err_q       <= 1'b0;
            err_count_q     <= 8'd0;
        end else begin
            state_q         <= state_d;
            prev_q          <= {col_n, row_n};
            dwell_q         <= dwell_d;
            exp_col_q       <= exp_col_d;
            last_col_q      <= last_col_d;
            shadow_q        <= shadow_d;
            frame_q         <= frame_d;
            frame_valid_q   <= frame_valid_d;
            frame_changed_q <= frame_changed_d;
            frame_count_q   <= frame_count_d;
            seq_err_q       <= seq_err_d;
            err_count_q     <= err_count_d;
        end
    end

    assign frame_col_4   = frame_q[4];
    assign frame_col_3   = frame_q[3];
    assign frame_col_2   = frame_q[2];
    assign frame_col_1   = frame_q[1];
    assign frame_col_0   = frame_q[0];
    assign frame_valid   = frame_valid_q;
    assign frame_changed = frame_changed_q;
    assign frame_count   = frame_count_q;
    assign seq_err       = seq_err_q;
    assign err_count     = err_count_q;

endmodule
